// File: rtl/shift_sequencer_pkg.sv
// Shared op and state encodings for the shift sequencer.
// Op values match the processor SHIFT unit.
package shift_sequencer_pkg;

    localparam logic [1:0] OP_NIL = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_RRC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// Combinational single-bit right shift step.
// Nil op passes data and carry through untouched.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] data_out,
    output logic             cout
);

    always_comb begin
        data_out = data;
        cout     = cin;
        case (op)
            OP_ASR: begin
                data_out = {data[WIDTH-1], data[WIDTH-1:1]};
                cout     = data[0];
            end
            OP_ROR: begin
                data_out = {data[0], data[WIDTH-1:1]};
                cout     = data[0];
            end
            OP_RRC: begin
                data_out = {cin, data[WIDTH-1:1]};
                cout     = data[0];
            end
            default: begin
                data_out = data;
                cout     = cin;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-N controller: one 1-bit step per clock,
// start/busy/done handshake, back-to-back starts accepted in DONE.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic             C_in,
    output logic [WIDTH-1:0] Y,
    output logic             C_out,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] step_y;
    logic             step_c;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data     (Y),
        .op       (op_q),
        .cin      (C_out),
        .data_out (step_y),
        .cout     (step_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            Y     <= '0;
            C_out <= 1'b0;
            op_q  <= OP_NIL;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_SHIFT: begin
                    Y     <= step_y;
                    C_out <= step_c;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    if (start) begin
                        Y     <= A;
                        C_out <= C_in;
                        op_q  <= op;
                        cnt   <= count;
                        if (count == '0 || op == OP_NIL) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
